// File: rtl/median_sort_p.sv
// median_sort_p -- streaming rank filter.
// Collects a frame of P unsigned W-bit samples, sorts them in place with an
// odd-even transposition network (one pass per clock, P passes), then emits
// the median, or a selectable rank, with a single-cycle strobe.
//
// Optional build macro: MEDIAN_RANK_SEL_EN adds the RANK input. RANK is
// latched with sample 0 and clamped to P-1.
//
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   DI    input sample (unsigned, W bits)
//   DSI   sample strobe; DI is taken on an edge where DSI=1 and RDY=1
//   RANK  rank select (only with MEDIAN_RANK_SEL_EN)
//   RDY   high while collecting (IDLE/LOAD); decoded from state only
//   DO    selected-rank result, registered; holds until the next DSO
//   DSO   result strobe, one cycle per frame

// Compare-exchange cell: lo/hi ordered, equal values pass straight through.
module median_sort_p_cas #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  always_comb begin
    if (a > b) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end
endmodule

module median_sort_p #(
  parameter int W = 8,
  parameter int P = 9
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [W-1:0]         DI,
  input  logic                 DSI,
`ifdef MEDIAN_RANK_SEL_EN
  input  logic [$clog2(P)-1:0] RANK,
`endif
  output logic                 RDY,
  output logic [W-1:0]         DO,
  output logic                 DSO
);
  localparam int CW = $clog2(P+1);
  localparam int PW = $clog2(P);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;
  state_t state;

  logic [P-1:0][W-1:0] s, s_nxt;
  logic [P-2:0][W-1:0] lo, hi;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       pc;
  logic [PW-1:0]       k;

  // One cell per adjacent pair; the pass parity chooses which cells take effect.
  for (genvar g = 0; g < P-1; g++) begin : g_cas
    median_sort_p_cas #(.W(W)) u_cas (
      .a (s[g]),
      .b (s[g+1]),
      .lo(lo[g]),
      .hi(hi[g])
    );
  end

  // Even pass: pairs (0,1),(2,3)..; odd pass: (1,2),(3,4)..
  // Active pairs never overlap, so each element is written at most once.
  always_comb begin
    s_nxt = s;
    for (int j = 0; j < P-1; j++) begin
      if (j[0] == pc[0]) begin
        s_nxt[j]   = lo[j];
        s_nxt[j+1] = hi[j];
      end
    end
  end

`ifdef MEDIAN_RANK_SEL_EN
  logic [PW-1:0] rank_q;
  assign k = (rank_q > PW'(P-1)) ? PW'(P-1) : rank_q;
`else
  assign k = PW'((P-1)/2);
`endif

  assign RDY = (state == IDLE) || (state == LOAD);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      s      <= '0;
      cnt    <= '0;
      pc     <= '0;
      DO     <= '0;
      DSO    <= 1'b0;
`ifdef MEDIAN_RANK_SEL_EN
      rank_q <= '0;
`endif
    end else begin
      DSO <= 1'b0;
      case (state)
        IDLE: begin
          if (DSI) begin
            s[0]   <= DI;
            cnt    <= CW'(1);
            state  <= LOAD;
`ifdef MEDIAN_RANK_SEL_EN
            rank_q <= RANK;
`endif
          end
        end
        LOAD: begin
          if (DSI) begin
            s[cnt] <= DI;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(P-1)) begin
              state <= SORT;
              pc    <= '0;
            end
          end
        end
        SORT: begin
          s  <= s_nxt;
          pc <= pc + PW'(1);
          if (pc == PW'(P-1)) state <= OUT;
        end
        OUT: begin
          DO    <= s[k];
          DSO   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_sort_p.sv
// Bench for median_sort_p at W=8, P=5: directed scenarios plus random
// frames checked against a sort-and-pick reference.
module tb_median_sort_p;
  localparam int W = 8;
  localparam int P = 5;

  logic         CLK  = 1'b0;
  logic         nRST = 1'b0;
  logic [W-1:0] DI   = '0;
  logic         DSI  = 1'b0;
  logic         RDY;
  logic [W-1:0] DO;
  logic         DSO;
`ifdef MEDIAN_RANK_SEL_EN
  logic [$clog2(P)-1:0] RANK = '0;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] fr [5];

  always #5 CLK = ~CLK;

  median_sort_p #(.W(W), .P(P)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .DI  (DI),
    .DSI (DSI),
`ifdef MEDIAN_RANK_SEL_EN
    .RANK(RANK),
`endif
    .RDY (RDY),
    .DO  (DO),
    .DSO (DSO)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends fr[] with 0..gmax idle cycles before each sample, optionally
  // strobes 99 while busy, then checks timing and the selected rank.
  // r0 is the rank presented with sample 0, r1 the rank driven afterwards.
  task automatic run_frame(input int gmax, input bit busy, input int r0, input int r1);
    logic [7:0] q[$];
    int lat, k, gaps;
    for (int i = 0; i < P; i++) begin
      gaps = $urandom_range(0, gmax);
      for (int g = 0; g < gaps; g++) begin
        DSI = 1'b0;
        tick();
        chk("gap_dso", DSO, 0);
      end
      DI  = fr[i];
      DSI = 1'b1;
`ifdef MEDIAN_RANK_SEL_EN
      if (i == 0) RANK = r0[$clog2(P)-1:0];
`endif
      chk("rdy_load", RDY, 1);
      tick();
      DSI = 1'b0;
`ifdef MEDIAN_RANK_SEL_EN
      if (i == 0) RANK = r1[$clog2(P)-1:0];
`endif
      q.push_back(fr[i]);
    end
    chk("rdy_sort", RDY, 0);
    lat = -1;
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      if (busy && n == 2) begin
        DI  = 8'd99;
        DSI = 1'b1;
      end
      tick();
      DSI = 1'b0;
      if (DSO) lat = n;
    end
    chk("latency", lat, P+1);
    q.sort();
`ifdef MEDIAN_RANK_SEL_EN
    k = (r0 > P-1) ? P-1 : r0;
`else
    k = (P-1)/2 + 0*(r0 + r1);
`endif
    chk("do_val", DO, q[k]);
    chk("rdy_out", RDY, 1);
    tick();
    chk("dso_clear", DSO, 0);
    chk("do_hold", DO, q[k]);
  endtask

  initial begin
    // reset held with random activity
    nRST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      DI  = 8'($urandom);
      DSI = 1'($urandom);
      tick();
      chk("rst_do", DO, 0);
      chk("rst_dso", DSO, 0);
      chk("rst_rdy", RDY, 1);
    end
    DSI  = 1'b0;
    nRST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_dso", DSO, 0);
    end

    // back-to-back burst
    fr = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    run_frame(0, 1'b0, 2, 2);

    // gapped with duplicates
    fr = '{8'd200, 8'd200, 8'd10, 8'd255, 8'd0};
    run_frame(3, 1'b0, 2, 2);

    // strobe while busy is dropped
    fr = '{8'd4, 8'd8, 8'd2, 8'd6, 8'd0};
    run_frame(0, 1'b1, 2, 2);
    fr = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    run_frame(0, 1'b0, 2, 2);

    // reset mid-frame
    for (int i = 0; i < 3; i++) begin
      DI  = 8'd250;
      DSI = 1'b1;
      tick();
    end
    DSI  = 1'b0;
    nRST = 1'b0;
    tick();
    chk("mid_rst_rdy", RDY, 1);
    chk("mid_rst_dso", DSO, 0);
    nRST = 1'b1;
    fr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    run_frame(1, 1'b0, 2, 2);

    // random frames, narrow value range sometimes to force duplicates
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < P; i++)
        fr[i] = (f % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      run_frame(3, 1'($urandom), 2, 2);
    end

`ifdef MEDIAN_RANK_SEL_EN
    fr = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    run_frame(0, 1'b0, 0, 0);
    run_frame(0, 1'b0, 4, 4);
    run_frame(0, 1'b0, 7, 7);
    run_frame(0, 1'b0, 2, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
